// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light encoding, phase codes and small helpers for the
// intersection controller and its timer.
package traffic_pkg;

  // 2-bit light head encoding shared with the per-head drivers.
  typedef logic [1:0] light_t;

  localparam light_t RED    = 2'd0;
  localparam light_t GREEN  = 2'd1;
  localparam light_t YELLOW = 2'd2;

  // Phase codes; these values are visible on the debug phase output.
  typedef enum logic [2:0] {
    PhMainGreen  = 3'd0,
    PhMainYellow = 3'd1,
    PhAllredA    = 3'd2,
    PhSideGreen  = 3'd3,
    PhSideYellow = 3'd4,
    PhAllredB    = 3'd5,
    PhWalk       = 3'd6
  } phase_e;

  // Timer load for a dwell of d cycles; a dwell of 0 behaves as 1.
  function automatic int unsigned dwell_load(int unsigned d);
    int unsigned r;
    r = (d == 0) ? 0 : d - 1;
    return r;
  endfunction

  // Main head colour shown in a phase; anything not main-green/yellow is RED.
  function automatic light_t main_of(phase_e p);
    light_t l;
    case (p)
      PhMainGreen:  l = GREEN;
      PhMainYellow: l = YELLOW;
      default:      l = RED;
    endcase
    return l;
  endfunction

  // Side head colour shown in a phase.
  function automatic light_t side_of(phase_e p);
    light_t l;
    case (p)
      PhSideGreen:  l = GREEN;
      PhSideYellow: l = YELLOW;
      default:      l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero; done while zero.
module phase_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: main/side road phase sequencer with latched side
// demand. Define PED_WALK_EN to add the pedestrian button, latch and WALK phase.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MAIN_CYC = 8,
  parameter int unsigned GREEN_SIDE_CYC = 4,
  parameter int unsigned YELLOW_CYC     = 2,
  parameter int unsigned ALLRED_CYC     = 1,
  parameter int unsigned WALK_CYC       = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
`endif
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LdMainGreen = CNT_W'(dwell_load(GREEN_MAIN_CYC));
  localparam logic [CNT_W-1:0] LdSideGreen = CNT_W'(dwell_load(GREEN_SIDE_CYC));
  localparam logic [CNT_W-1:0] LdYellow    = CNT_W'(dwell_load(YELLOW_CYC));
  localparam logic [CNT_W-1:0] LdAllred    = CNT_W'(dwell_load(ALLRED_CYC));
  localparam logic [CNT_W-1:0] LdWalk      = CNT_W'(dwell_load(WALK_CYC));

  phase_e           phase_q, phase_d;
  logic             side_pend_q, ped_pend_q;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  light_t           main_q, side_q;
  logic             enter_side, enter_walk;

  // Next-phase decision; unused codes fall back to main green.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PhMainGreen:  if (tmr_done && (side_pend_q || ped_pend_q)) phase_d = PhMainYellow;
      PhMainYellow: if (tmr_done) phase_d = PhAllredA;
      PhAllredA:    if (tmr_done) phase_d = PhSideGreen;
      PhSideGreen:  if (tmr_done) phase_d = PhSideYellow;
      PhSideYellow: if (tmr_done) phase_d = PhAllredB;
      PhAllredB:    if (tmr_done) phase_d = ped_pend_q ? PhWalk : PhMainGreen;
`ifdef PED_WALK_EN
      PhWalk:       if (tmr_done) phase_d = PhMainGreen;
`endif
      default:      phase_d = PhMainGreen;
    endcase
  end

  // Reload the timer with the new phase's dwell whenever the phase changes.
  always_comb begin
    tmr_load = (phase_d != phase_q);
    tmr_val  = '0;
    case (phase_d)
      PhMainGreen:  tmr_val = LdMainGreen;
      PhMainYellow: tmr_val = LdYellow;
      PhAllredA:    tmr_val = LdAllred;
      PhSideGreen:  tmr_val = LdSideGreen;
      PhSideYellow: tmr_val = LdYellow;
      PhAllredB:    tmr_val = LdAllred;
      PhWalk:       tmr_val = LdWalk;
      default:      tmr_val = '0;
    endcase
  end

  assign enter_side = (phase_d == PhSideGreen) && (phase_q != PhSideGreen);
  assign enter_walk = (phase_d == PhWalk) && (phase_q != PhWalk);

  // Phase register, side demand latch (set beats clear) and registered heads.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= PhMainGreen;
      side_pend_q <= 1'b0;
      main_q      <= GREEN;
      side_q      <= RED;
    end else begin
      phase_q     <= phase_d;
      side_pend_q <= side_req | (side_pend_q & ~enter_side);
      main_q      <= main_of(phase_d);
      side_q      <= side_of(phase_d);
    end
  end

`ifdef PED_WALK_EN
  logic walk_q;

  // Pedestrian latch (set beats clear) and registered walk lamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_req | (ped_pend_q & ~enter_walk);
      walk_q     <= (phase_d == PhWalk);
    end
  end

  assign walk = walk_q;
`else
  logic unused_walk;

  assign ped_pend_q  = 1'b0;
  assign walk        = 1'b0;
  assign unused_walk = enter_walk;
`endif

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(LdMainGreen)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign main_light = main_q;
  assign side_light = side_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: a phase/age reference model
// driven by the same inputs is compared against the DUT every cycle, plus
// directed scenarios with hand-computed expectations and randomized traffic.
module tb_intersection_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] main_light, side_light;
  logic       walk;
  logic [2:0] phase;
  bit         chk_en = 1'b0;

`ifdef PED_WALK_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  always #5 clock = ~clock;

  intersection_controller dut (
    .clock     (clock),
    .reset     (reset),
    .side_req  (side_req),
`ifdef PED_WALK_EN
    .ped_req   (ped_req),
`endif
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk),
    .phase     (phase)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus cycles spent in it, per-phase tables.
  int dw[7]     = '{8, 2, 1, 4, 2, 1, 3};
  int m_main[7] = '{1, 2, 0, 0, 0, 0, 0};
  int m_side[7] = '{0, 0, 0, 1, 2, 0, 0};
  int m_ph  = 0;
  int m_age = 0;
  bit m_sp  = 1'b0;
  bit m_pp  = 1'b0;

  always @(posedge clock) begin
    int nph;
    bit adv;
    if (reset) begin
      m_ph = 0; m_age = 0; m_sp = 1'b0; m_pp = 1'b0;
    end else begin
      adv = (m_age >= dw[m_ph] - 1);
      if (m_ph == 0) adv = adv && (m_sp || m_pp);
      nph = m_ph;
      if (adv) begin
        case (m_ph)
          0: nph = 1;
          1: nph = 2;
          2: nph = 3;
          3: nph = 4;
          4: nph = 5;
          5: nph = m_pp ? 6 : 0;
          default: nph = 0;
        endcase
      end
      m_sp  = side_req || (m_sp && !(nph == 3 && m_ph != 3));
      m_pp  = PedEn && (ped_req || (m_pp && !(nph == 6 && m_ph != 6)));
      m_age = adv ? 0 : m_age + 1;
      m_ph  = nph;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    int exp_t;
    if (chk_en) begin
      exp_t = dw[m_ph] - 1 - m_age;
      if (exp_t < 0) exp_t = 0;
      check("phase", int'(phase), m_ph);
      check("main_light", int'(main_light), m_main[m_ph]);
      check("side_light", int'(side_light), m_side[m_ph]);
      check("walk", int'(walk), (m_ph == 6) ? 1 : 0);
      check("timer", int'(dut.u_timer.count_q), exp_t);
      check("side_pend", int'(dut.side_pend_q), int'(m_sp));
      check("heads_exclusive", int'(main_light != 2'd0 && side_light != 2'd0), 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input int p, input int lim, input string name);
    int n;
    n = 0;
    while (int'(phase) != p && n < lim) begin
      step();
      n++;
    end
    check(name, int'(phase), p);
  endtask

  initial begin
    int n;
    // Reset for 2 cycles and pin the reset state.
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    check("rst_phase", int'(phase), 0);
    check("rst_main", int'(main_light), 1);
    check("rst_side", int'(side_light), 0);
    check("rst_walk", int'(walk), 0);
    check("rst_timer", int'(dut.u_timer.count_q), 7);
    check("rst_pend", int'(dut.side_pend_q), 0);

    // Idle: main green rests.
    repeat (100) step();
    check("idle_phase", int'(phase), 0);
    check("idle_main", int'(main_light), 1);

    // One-cycle request sampled at the 3rd edge after reset.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    repeat (4) step();
    check("pulse_mg_last", int'(phase), 0);
    step();
    check("pulse_my", int'(phase), 1);
    repeat (3) step();
    check("pulse_sg", int'(phase), 3);
    check("pulse_sg_side", int'(side_light), 1);
    check("pulse_sg_main", int'(main_light), 0);
    repeat (7) step();
    check("pulse_back_mg", int'(phase), 0);
    repeat (20) step();
    check("pulse_hold_mg", int'(phase), 0);

    // Continuous request: 18-cycle period between side-green entries.
    side_req = 1'b1;
    wait_phase(3, 40, "held_first_sg");
    for (int k = 0; k < 2; k++) begin
      repeat (17) step();
      check("held_pre_sg", int'(phase), 2);
      step();
      check("held_period_sg", int'(phase), 3);
    end
    side_req = 1'b0;
    wait_phase(0, 40, "held_drain");

    // Request landing on the side-green entry edge must survive.
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    wait_phase(2, 40, "same_edge_ara");
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    check("same_edge_sg", int'(phase), 3);
    check("same_edge_pend", int'(dut.side_pend_q), 1);
    wait_phase(0, 40, "same_edge_mg");
    n = 0;
    while (int'(phase) == 0 && n < 40) begin
      step();
      n++;
    end
    check("same_edge_gap", n, 8);
    check("same_edge_my", int'(phase), 1);

    // Reset during the 3rd cycle of side green.
    wait_phase(3, 40, "rst_mid_sg");
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_phase", int'(phase), 0);
    check("rst_mid_main", int'(main_light), 1);
    check("rst_mid_side", int'(side_light), 0);
    check("rst_mid_pend", int'(dut.side_pend_q), 0);
    check("rst_mid_timer", int'(dut.u_timer.count_q), 7);

`ifdef PED_WALK_EN
    // Pedestrian-only request: full side cycle then a 3-cycle walk.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(5, 60, "ped_arb");
    step();
    check("ped_walk_phase", int'(phase), 6);
    check("ped_walk_on", int'(walk), 1);
    check("ped_walk_main", int'(main_light), 0);
    check("ped_walk_side", int'(side_light), 0);
    step();
    step();
    check("ped_walk_last", int'(walk), 1);
    step();
    check("ped_walk_off", int'(walk), 0);
    check("ped_back_mg", int'(phase), 0);
`endif

    // Randomized traffic with sparse resets, checked by the model.
    repeat (3000) begin
      side_req = ($urandom_range(0, 11) == 0);
      ped_req  = PedEn && ($urandom_range(0, 29) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      step();
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset    = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
